mdu_param: RTL and testbench
============================

# mdu_param

Parametrised multiply/divide unit for the E stage of the pipelined processor, successor to the fixed 32-bit MDU. It adds configurable width and per-class latency, multiply-accumulate modes (MADD/MADDU/MSUB/MSUBU), defined divide-by-zero results and a clean exception abort. It owns the HI/LO registers. The stall controller stalls MDU-dependent instructions with `busy || start`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; ≥ 8.
- `MULT_LAT`, 5, busy cycles for multiply-class ops; ≥ 1.
- `DIV_LAT`, 10, busy cycles for divide-class ops; ≥ 1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  op valid this cycle (E-stage instruction is an MDU op).
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10 MFHI, 11 MFLO; 12–15 no-op.
- `rs`  in  WIDTH  first operand (forwarded value).
- `rt`  in  WIDTH  second operand (forwarded value).
- `abort`  in  1  exception request; kills pending work.
- `busy`  out  1  multi-cycle op in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `out`  out  WIDTH  combinational: `hi` when op==MFHI, else `lo`.

## Operation
- States: IDLE, RUN.
- In IDLE, `start` && !`abort` with op 0–7: latch the result into a 2·WIDTH pending register, load the down-counter with MULT_LAT (ops 0,1,4–7) or DIV_LAT (2,3), go to RUN.
- MULT/MULTU: {hi,lo} = rs·rt, signed/unsigned.
- MADD(U)/MSUB(U): {hi,lo} ± rs·rt, using HI/LO as they are at start. Modulo 2^(2·WIDTH).
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero: lo = all ones, hi = rs.
- Signed MIN/−1: lo = MIN, hi = 0.
- MTHI/MTLO in IDLE with `start` && !`abort`: write hi/lo = rs at the next edge. No busy.
- MFHI/MFLO: read only. No state change.
- In RUN:
  - The counter decrements each cycle.
  - On the cycle where the counter reads 1, commit pending to {hi,lo} and return to IDLE.
  - `start` is ignored in RUN; the stall controller guarantees this never happens.
- `abort` in any state:
  - Pending result is discarded; hi/lo keep their pre-op values.
  - Next state is IDLE.
  - A `start` in the same cycle is ignored.
- Reset: busy=0, hi=0, lo=0, state IDLE, counter 0; `out`=0. Reset mid-RUN discards the pending result.

## Timing
- `start` sampled at edge k → busy=1 during cycles k+1 … k+LAT.
- hi/lo take the new value at the edge ending cycle k+LAT; busy=0 in the same cycle they become visible.
- LAT=1: busy for exactly one cycle.
- Back-to-back: a new `start` is accepted in the first cycle with busy=0.
- MTHI/MTLO: hi/lo updated 1 edge after `start`.
- `out` has zero latency from `op`/hi/lo.
- `abort` asserted in cycle c → busy=0 in cycle c+1; no commit occurs in or after cycle c, even if c = k+LAT.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV rs=−7, rt=2 → busy high 10 cycles; then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU rs=7, rt=0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- MTHI 1 and MTLO 0xFFFFFFFF on consecutive cycles, then MADDU rs=1, rt=1 → hi=2, lo=0. Then MSUB rs=1, rt=1 → hi=1, lo=0xFFFFFFFF.
- MULT started, `abort` on busy cycle 3 → busy=0 next cycle; hi/lo unchanged. Repeat with `abort` on the final busy cycle → still no commit.
- `reset` pulsed low mid-DIV → busy, hi, lo = 0 immediately. After release, MFHI gives `out`=0.
- Parameter sweep WIDTH=16, MULT_LAT=1, DIV_LAT=3: MULT 0x8000·0x8000 → hi=0x4000, lo=0; busy for exactly 1 cycle. Back-to-back MULT accepted on the first cycle busy=0.

Source files
------------

// File: rtl/mdu_param.sv
// ---------------------------------------------------------------------------
// mdu_param -- parametrised multiply/divide unit for the E stage.
//
// Owns the HI/LO registers. Multiply, multiply-accumulate and divide results
// are computed combinationally when the op is accepted. They are parked in a
// 2*WIDTH pending register, then committed to {hi,lo} after a fixed
// per-class latency. An abort, or reset, drops the pending value.
//
// Parameters:
//   WIDTH     operand and HI/LO width (>= 8)
//   MULT_LAT  busy cycles for MULT/MULTU/MADD(U)/MSUB(U) (>= 1)
//   DIV_LAT   busy cycles for DIV/DIVU (>= 1)
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   asynchronous, active-low; clears all state
//   start  in   E-stage instruction is an MDU op
//   op     in   4-bit opcode (0 MULT .. 11 MFLO, 12-15 no-op)
//   rs/rt  in   forwarded operands
//   abort  in   exception request, kills pending work
//   busy   out  multi-cycle op in flight
//   hi/lo  out  HI/LO registers
//   out    out  hi when op==MFHI, else lo (combinational)
// ---------------------------------------------------------------------------

// Truncating divider. Both signed and unsigned modes work on magnitudes,
// and the signs are fixed up afterwards. Signed MIN/-1 falls out naturally:
// |MIN| is 2^(W-1) as an unsigned value, so the negated quotient wraps
// back to MIN with a zero remainder.
module mdu_param_div #(
    parameter int W = 32
) (
    input  logic         sgn_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);
    logic         a_neg, b_neg, b_zero;
    logic [W-1:0] abs_a, abs_b, safe_b, q_u, r_u;

    always_comb begin
        a_neg  = sgn_i & a_i[W-1];
        b_neg  = sgn_i & b_i[W-1];
        abs_a  = a_neg ? (~a_i + W'(1)) : a_i;
        abs_b  = b_neg ? (~b_i + W'(1)) : b_i;
        b_zero = (b_i == '0);
        // Keep the divider away from x/0 so simulation stays defined;
        // the zero-divisor case is replaced below anyway.
        safe_b = b_zero ? W'(1) : abs_b;
        q_u    = abs_a / safe_b;
        r_u    = abs_a % safe_b;
        if (b_zero) begin
            quo_o = '1;
            rem_o = a_i;
        end else begin
            quo_o = (a_neg ^ b_neg) ? (~q_u + W'(1)) : q_u;
            // Remainder takes the sign of the dividend.
            rem_o = a_neg ? (~r_u + W'(1)) : r_u;
        end
    end
endmodule

module mdu_param #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);
    localparam int W2      = 2 * WIDTH;
    localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    pend_q, pend_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    // ---------------------------------------------------------------
    // Datapath: one 2W multiplier serves signed and unsigned forms.
    // Sign- or zero-extending to 2W and keeping the low 2W bits of the
    // product gives the exact signed/unsigned result modulo 2^(2W).
    // ---------------------------------------------------------------
    logic          mul_sgn;
    logic [W2-1:0] ext_a, ext_b, prod, hilo, acc_add, acc_sub;
    logic [WIDTH-1:0] div_q, div_r;
    logic [W2-1:0] result;

    assign mul_sgn = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    assign ext_a   = {{WIDTH{mul_sgn & rs[WIDTH-1]}}, rs};
    assign ext_b   = {{WIDTH{mul_sgn & rt[WIDTH-1]}}, rt};
    assign prod    = ext_a * ext_b;
    assign hilo    = {hi_q, lo_q};
    // Accumulate modes read HI/LO as they stand when the op is accepted.
    assign acc_add = hilo + prod;
    assign acc_sub = hilo - prod;

    mdu_param_div #(.W(WIDTH)) u_div (
        .sgn_i (op == OP_DIV),
        .a_i   (rs),
        .b_i   (rt),
        .quo_o (div_q),
        .rem_o (div_r)
    );

    always_comb begin
        result = prod;
        case (op)
            OP_DIV, OP_DIVU:   result = {div_r, div_q};
            OP_MADD, OP_MADDU: result = acc_add;
            OP_MSUB, OP_MSUBU: result = acc_sub;
            default:           result = prod;
        endcase
    end

    // ---------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (abort) begin
            // Abort wins over everything, including a same-cycle start
            // and a commit due this cycle.
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                {hi_d, lo_d} = pend_q;
                state_d      = S_IDLE;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    pend_d  = result;
                    cnt_d   = CW'(MULT_LAT);
                    state_d = S_RUN;
                end
                OP_DIV, OP_DIVU: begin
                    pend_d  = result;
                    cnt_d   = CW'(DIV_LAT);
                    state_d = S_RUN;
                end
                OP_MTHI: hi_d = rs;
                OP_MTLO: lo_d = rs;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign out  = (op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// ---------------------------------------------------------------------------
// tb_mdu_param -- directed bench for mdu_param. One instance at the default
// 32-bit configuration, one at WIDTH=16 / MULT_LAT=1 / DIV_LAT=3.
// ---------------------------------------------------------------------------
module tb_mdu_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        abort;

    logic        start32;
    logic [3:0]  op32;
    logic [31:0] rs32, rt32;
    logic        busy32;
    logic [31:0] hi32, lo32, out32;

    logic        start16;
    logic [3:0]  op16;
    logic [15:0] rs16, rt16;
    logic        busy16;
    logic [15:0] hi16, lo16, out16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_param u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
        .rs(rs32), .rt(rt32), .abort(abort),
        .busy(busy32), .hi(hi32), .lo(lo32), .out(out32)
    );

    mdu_param #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16),
        .rs(rs16), .rt(rt16), .abort(1'b0),
        .busy(busy16), .hi(hi16), .lo(lo16), .out(out16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then count busy cycles (bounded).
    task automatic run32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        op32 = o; rs32 = a; rt32 = b; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        n = 0;
        while (busy32 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic run16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int n);
        op16 = o; rs16 = a; rt16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        n = 0;
        while (busy16 && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; abort = 1'b0;
        start32 = 1'b0; op32 = 4'd0; rs32 = '0; rt32 = '0;
        start16 = 1'b0; op16 = 4'd0; rs16 = '0; rt16 = '0;
        repeat (3) tick();
        chk("rst_busy", busy32, 0);
        chk("rst_hi",   hi32,   0);
        chk("rst_lo",   lo32,   0);
        chk("rst_out",  out32,  0);
        chk("rst_busy16", busy16, 0);
        reset = 1'b1;
        tick();

        // MULT -2 * 3
        run32(4'd0, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_lat", n, 5);
        chk("mult_hi", hi32, 64'hFFFF_FFFF);
        chk("mult_lo", lo32, 64'hFFFF_FFFA);
        op32 = 4'd10; #1;
        chk("mfhi_out", out32, 64'hFFFF_FFFF);
        op32 = 4'd11; #1;
        chk("mflo_out", out32, 64'hFFFF_FFFA);

        // MULTU same operands
        run32(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        chk("multu_hi", hi32, 64'h2);
        chk("multu_lo", lo32, 64'hFFFF_FFFA);

        // DIV -7 / 2
        run32(4'd2, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_lat", n, 10);
        chk("div_lo", lo32, 64'hFFFF_FFFD);
        chk("div_hi", hi32, 64'hFFFF_FFFF);

        // DIVU 7 / 0
        run32(4'd3, 32'd7, 32'd0, n);
        chk("divz_lo", lo32, 64'hFFFF_FFFF);
        chk("divz_hi", hi32, 64'h7);

        // DIV MIN / -1
        run32(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divmin_lo", lo32, 64'h8000_0000);
        chk("divmin_hi", hi32, 64'h0);

        // MTHI / MTLO back to back
        op32 = 4'd8; rs32 = 32'd1; start32 = 1'b1;
        tick();
        chk("mthi_hi", hi32, 64'h1);
        chk("mthi_busy", busy32, 0);
        op32 = 4'd9; rs32 = 32'hFFFF_FFFF;
        tick();
        start32 = 1'b0;
        chk("mtlo_lo", lo32, 64'hFFFF_FFFF);

        // MADDU 1*1: {1,FFFFFFFF}+1 = {2,0}
        run32(4'd5, 32'd1, 32'd1, n);
        chk("maddu_hi", hi32, 64'h2);
        chk("maddu_lo", lo32, 64'h0);
        // MSUB 1*1: {2,0}-1 = {1,FFFFFFFF}
        run32(4'd6, 32'd1, 32'd1, n);
        chk("msub_hi", hi32, 64'h1);
        chk("msub_lo", lo32, 64'hFFFF_FFFF);

        // Abort on busy cycle 3
        op32 = 4'd0; rs32 = 32'd5; rt32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        chk("abt_busy1", busy32, 1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_busy_off", busy32, 0);
        repeat (6) tick();
        chk("abt_hi", hi32, 64'h1);
        chk("abt_lo", lo32, 64'hFFFF_FFFF);

        // Abort on the final busy cycle
        op32 = 4'd0; rs32 = 32'd5; rt32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        repeat (4) tick();
        chk("abtl_busy5", busy32, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abtl_busy_off", busy32, 0);
        tick();
        chk("abtl_hi", hi32, 64'h1);
        chk("abtl_lo", lo32, 64'hFFFF_FFFF);

        // Start together with abort in IDLE is ignored
        op32 = 4'd8; rs32 = 32'h1234; start32 = 1'b1; abort = 1'b1;
        tick();
        start32 = 1'b0; abort = 1'b0;
        chk("abt_start_hi", hi32, 64'h1);

        // Reset mid-DIV
        run32(4'd3, 32'd100, 32'd7, n);
        op32 = 4'd2; rs32 = 32'd100; rt32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy32, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy32, 0);
        chk("mid_rst_hi", hi32, 0);
        chk("mid_rst_lo", lo32, 0);
        tick();
        reset = 1'b1;
        op32 = 4'd10;
        tick();
        chk("post_rst_out", out32, 0);
        repeat (12) tick();
        chk("post_rst_lo", lo32, 0);

        // WIDTH=16, MULT_LAT=1, DIV_LAT=3
        run16(4'd0, 16'h8000, 16'h8000, n);
        chk("w16_mult_lat", n, 1);
        chk("w16_mult_hi", hi16, 64'h4000);
        chk("w16_mult_lo", lo16, 64'h0);
        // Issued in the first cycle with busy=0
        run16(4'd1, 16'd3, 16'd5, n);
        chk("w16_b2b_lat", n, 1);
        chk("w16_b2b_lo", lo16, 64'd15);
        chk("w16_b2b_hi", hi16, 64'h0);
        run16(4'd2, 16'hFFF9, 16'd2, n);
        chk("w16_div_lat", n, 3);
        chk("w16_div_lo", lo16, 64'hFFFD);
        chk("w16_div_hi", hi16, 64'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
